// File: rtl/dsocm_bram_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and one DSOCM BRAM port.
// Big-endian bit numbering: bit 0 is the MSB.
interface dsocm_bram_arbiter_if #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int NWE = 4
);
  logic            Init_Done;
  logic            Req0, Req1;
  logic            RNW0, RNW1;
  logic [0:AW-1]   Addr0, Addr1;
  logic [0:DW-1]   WrData0, WrData1;
  logic [0:NWE-1]  BE0, BE1;
  logic            Ack0, Ack1;
  logic [0:DW-1]   Rd_Data;
  logic            RdValid0, RdValid1;
  logic            BRAM_EN;
  logic [0:NWE-1]  BRAM_WEN;
  logic [0:AW-1]   BRAM_Addr;
  logic [0:DW-1]   BRAM_Dout;
  logic [0:DW-1]   BRAM_Din;

  // Arbiter side
  modport slave (
    input  Req0, Req1, RNW0, RNW1, Addr0, Addr1, WrData0, WrData1, BE0, BE1,
    input  BRAM_Din,
    output Init_Done, Ack0, Ack1, Rd_Data, RdValid0, RdValid1,
    output BRAM_EN, BRAM_WEN, BRAM_Addr, BRAM_Dout
  );

  // Requesters plus the BRAM itself
  modport master (
    output Req0, Req1, RNW0, RNW1, Addr0, Addr1, WrData0, WrData1, BE0, BE1,
    output BRAM_Din,
    input  Init_Done, Ack0, Ack1, Rd_Data, RdValid0, RdValid1,
    input  BRAM_EN, BRAM_WEN, BRAM_Addr, BRAM_Dout
  );
endinterface

// File: rtl/dsocm_bram_arbiter.sv
// Two-requester round-robin controller for one DSOCM BRAM port.
// Zero-fills the BRAM after reset, then accepts one access per cycle.
module dsocm_bram_arbiter #(
  parameter int C_MEMSIZE     = 'h4000,
  parameter int C_PORT_AWIDTH = 32,
  parameter int C_PORT_DWIDTH = 32,
  parameter int C_NUM_WE      = 4,
  parameter int C_INIT_CLEAR  = 1
) (
  input  logic                 Clk,
  input  logic                 Rst,
  dsocm_bram_arbiter_if.slave  bus
);

  localparam int unsigned N  = C_MEMSIZE / 4;
  localparam int unsigned CW = $clog2(N) + 1;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                    r_state;
  logic [CW-1:0]             r_cnt;
  logic                      r_done;
  logic                      r_prio;
  logic                      r_en;
  logic [0:C_NUM_WE-1]       r_wen;
  logic [0:C_PORT_AWIDTH-1]  r_addr;
  logic [0:C_PORT_DWIDTH-1]  r_dout;
  logic                      r_s1_rd;
  logic                      r_s1_id;
  logic                      r_rv0, r_rv1;
  logic [0:C_PORT_DWIDTH-1]  r_rd_hold;

  logic                      w_gate;
  logic                      w_ack0, w_ack1, w_hs;
  logic                      w_rnw;
  logic [0:C_PORT_AWIDTH-1]  w_addr;
  logic [0:C_PORT_DWIDTH-1]  w_wdata;
  logic [0:C_NUM_WE-1]       w_be;

  // Round-robin grant; nothing is accepted during reset or before zero-fill ends
  assign w_gate  = r_done & ~Rst;
  assign w_ack0  = w_gate & bus.Req0 & (~bus.Req1 | ~r_prio);
  assign w_ack1  = w_gate & bus.Req1 & (~bus.Req0 |  r_prio);
  assign w_hs    = w_ack0 | w_ack1;
  assign w_rnw   = w_ack1 ? bus.RNW1    : bus.RNW0;
  assign w_addr  = w_ack1 ? bus.Addr1   : bus.Addr0;
  assign w_wdata = w_ack1 ? bus.WrData1 : bus.WrData0;
  assign w_be    = w_ack1 ? bus.BE1     : bus.BE0;

  assign bus.Ack0      = w_ack0;
  assign bus.Ack1      = w_ack1;
  assign bus.Init_Done = r_done;
  assign bus.BRAM_EN   = r_en;
  assign bus.BRAM_WEN  = r_wen;
  assign bus.BRAM_Addr = r_addr;
  assign bus.BRAM_Dout = r_dout;
  assign bus.RdValid0  = r_rv0;
  assign bus.RdValid1  = r_rv1;
  // The BRAM output register is the capture stage: pass it through on the
  // strobe cycle so latency stays at two, and hold it in r_rd_hold afterwards.
  assign bus.Rd_Data   = (r_rv0 | r_rv1) ? bus.BRAM_Din : r_rd_hold;

  // Control FSM, BRAM port registers and read-return pipeline
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state   <= (C_INIT_CLEAR != 0) ? ST_INIT : ST_RUN;
      r_cnt     <= '0;
      r_done    <= 1'b0;
      r_prio    <= 1'b0;
      r_en      <= 1'b0;
      r_wen     <= '0;
      r_addr    <= '0;
      r_dout    <= '0;
      r_s1_rd   <= 1'b0;
      r_s1_id   <= 1'b0;
      r_rv0     <= 1'b0;
      r_rv1     <= 1'b0;
      r_rd_hold <= '0;
    end else begin
      r_rv0 <= r_s1_rd & ~r_s1_id;
      r_rv1 <= r_s1_rd &  r_s1_id;
      if (r_rv0 | r_rv1) r_rd_hold <= bus.BRAM_Din;

      case (r_state)
        ST_INIT: begin
          r_s1_rd <= 1'b0;
          if (r_cnt == CW'(N)) begin
            r_en    <= 1'b0;
            r_wen   <= '0;
            r_done  <= 1'b1;
            r_state <= ST_RUN;
          end else begin
            r_en   <= 1'b1;
            r_wen  <= '1;
            r_addr <= C_PORT_AWIDTH'(r_cnt) << 2;
            r_dout <= '0;
            r_cnt  <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_done <= 1'b1;
          if (w_hs) begin
            r_en    <= 1'b1;
            r_addr  <= {w_addr[0:C_PORT_AWIDTH-3], 2'b00};
            r_wen   <= w_rnw ? '0 : w_be;
            if (!w_rnw) r_dout <= w_wdata;
            r_s1_rd <= w_rnw;
            r_s1_id <= w_ack1;
            r_prio  <= w_ack0;
          end else begin
            r_en    <= 1'b0;
            r_wen   <= '0;
            r_s1_rd <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dsocm_bram_arbiter.sv
// Scoreboard bench for dsocm_bram_arbiter with a behavioural BRAM and a
// word-array reference model of memory contents and round-robin priority.
module tb_dsocm_bram_arbiter;

  localparam int MEMSIZE = 'h40;
  localparam int NW      = MEMSIZE / 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dsocm_bram_arbiter_if #(.AW(32), .DW(32), .NWE(4)) bus ();

  dsocm_bram_arbiter #(
    .C_MEMSIZE(MEMSIZE), .C_PORT_AWIDTH(32), .C_PORT_DWIDTH(32),
    .C_NUM_WE(4), .C_INIT_CLEAR(1)
  ) dut (.Clk(clk), .Rst(rst), .bus(bus));

  // Requester drive
  logic        req [2];
  logic        rnw [2];
  logic [31:0] adr [2];
  logic [31:0] wd  [2];
  logic [3:0]  be  [2];
  assign bus.Req0 = req[0];  assign bus.Req1 = req[1];
  assign bus.RNW0 = rnw[0];  assign bus.RNW1 = rnw[1];
  assign bus.Addr0 = adr[0]; assign bus.Addr1 = adr[1];
  assign bus.WrData0 = wd[0]; assign bus.WrData1 = wd[1];
  assign bus.BE0 = be[0];    assign bus.BE1 = be[1];

  // Behavioural BRAM: read-first, registered output
  logic [31:0] bram [NW];
  logic [31:0] w_ba, w_bd, r_bdin;
  logic [3:0]  w_bw;
  assign w_ba = bus.BRAM_Addr;
  assign w_bd = bus.BRAM_Dout;
  assign w_bw = bus.BRAM_WEN;
  assign bus.BRAM_Din = r_bdin;
  always @(posedge clk) begin
    if (bus.BRAM_EN) begin
      r_bdin <= bram[w_ba[5:2]];
      for (int j = 0; j < 4; j++)
        if (w_bw[j]) bram[w_ba[5:2]][8*j +: 8] <= w_bd[8*j +: 8];
    end
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model
  typedef struct { bit id; logic [31:0] data; int unsigned cyc; } sb_t;
  sb_t         sbq [$];
  logic [31:0] mem_ref [NW];
  bit          prio;
  bit          run;
  logic [31:0] last_rd;
  bit          pv, prnw;
  logic [31:0] pa, pwd;
  logic [3:0]  pbe;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] b);
    logic [31:0] w = old;
    for (int j = 0; j < 4; j++) if (b[j]) w[8*j +: 8] = d[8*j +: 8];
    return w;
  endfunction

  // Read-return monitor
  always @(negedge clk) begin
    sb_t e;
    if (bus.RdValid0 || bus.RdValid1) begin
      chk("rdvalid_both", {31'b0, bus.RdValid0 & bus.RdValid1}, 32'd0);
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL rdvalid_unexpected: got RdValid0=%b RdValid1=%b expected none (cycle %0d)",
                 bus.RdValid0, bus.RdValid1, cyc);
      end else begin
        e = sbq.pop_front();
        chk("rd_id", {31'b0, bus.RdValid1}, {31'b0, e.id});
        chk("rd_data", bus.Rd_Data, e.data);
        chk("rd_latency", cyc, e.cyc);
        last_rd = e.data;
      end
    end else if (run) begin
      chk("rd_hold", bus.Rd_Data, last_rd);
    end
  end

  // One clock of stimulus: check arbitration and the previous access, update model
  task automatic step(output bit acc0, output bit acc1);
    bit e0, e1;
    int r, idx;
    @(negedge clk);
    e0 = run && req[0] && (!req[1] || !prio);
    e1 = run && req[1] && (!req[0] ||  prio);
    chk("ack0", {31'b0, bus.Ack0}, {31'b0, e0});
    chk("ack1", {31'b0, bus.Ack1}, {31'b0, e1});
    if (pv) begin
      chk("bram_en", {31'b0, bus.BRAM_EN}, 32'd1);
      chk("bram_addr", bus.BRAM_Addr, pa & 32'hFFFF_FFFC);
      chk("bram_wen", {28'b0, bus.BRAM_WEN}, prnw ? 32'd0 : {28'b0, pbe});
      if (!prnw) chk("bram_dout", bus.BRAM_Dout, pwd);
    end else if (run) begin
      chk("bram_idle_en", {31'b0, bus.BRAM_EN}, 32'd0);
      chk("bram_idle_wen", {28'b0, bus.BRAM_WEN}, 32'd0);
    end
    pv = e0 || e1;
    if (pv) begin
      r    = e1 ? 1 : 0;
      pa   = adr[r]; pwd = wd[r]; pbe = be[r]; prnw = rnw[r];
      idx  = int'((adr[r] >> 2) % NW);
      if (rnw[r]) sbq.push_back('{id: bit'(r), data: mem_ref[idx], cyc: cyc + 2});
      else        mem_ref[idx] = merge(mem_ref[idx], wd[r], be[r]);
      prio = (r == 0);
    end
    acc0 = e0; acc1 = e1;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    bit a0, a1;
    repeat (n) step(a0, a1);
  endtask

  task automatic do_op(input int r, input bit rd, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b);
    bit a0, a1, got;
    int n = 0;
    req[r] = 1'b1; rnw[r] = rd; adr[r] = a; wd[r] = d; be[r] = b;
    got = 1'b0;
    while (!got && n < 20) begin
      step(a0, a1);
      got = (r == 0) ? a0 : a1;
      n++;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL ack_timeout: requester %0d got no Ack within 20 cycles expected Ack", r);
    end
    req[r] = 1'b0;
  endtask

  // Reset, reset-value checks and zero-fill sequence
  task automatic init_seq();
    run = 0; pv = 0; rst = 1'b1; sbq.delete();
    req[0] = 1'b1; rnw[0] = 1'b1; adr[0] = '0; req[1] = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_en", {31'b0, bus.BRAM_EN}, 32'd0);
    chk("rst_wen", {28'b0, bus.BRAM_WEN}, 32'd0);
    chk("rst_addr", bus.BRAM_Addr, 32'd0);
    chk("rst_dout", bus.BRAM_Dout, 32'd0);
    chk("rst_rdv", {30'b0, bus.RdValid0, bus.RdValid1}, 32'd0);
    chk("rst_rddata", bus.Rd_Data, 32'd0);
    chk("rst_done", {31'b0, bus.Init_Done}, 32'd0);
    chk("rst_ack0", {31'b0, bus.Ack0}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < NW; i++) begin
      @(negedge clk);
      chk("init_en", {31'b0, bus.BRAM_EN}, 32'd1);
      chk("init_wen", {28'b0, bus.BRAM_WEN}, 32'hF);
      chk("init_addr", bus.BRAM_Addr, 32'(i * 4));
      chk("init_dout", bus.BRAM_Dout, 32'd0);
      chk("init_done_low", {31'b0, bus.Init_Done}, 32'd0);
      chk("init_ack0", {31'b0, bus.Ack0}, 32'd0);
    end
    @(negedge clk);
    chk("init_end_en", {31'b0, bus.BRAM_EN}, 32'd0);
    chk("init_done", {31'b0, bus.Init_Done}, 32'd1);
    req[0] = 1'b0;
    for (int i = 0; i < NW; i++) mem_ref[i] = '0;
    prio = 0; last_rd = '0; run = 1;
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running at %0t expected finish", $time);
    $fatal(1);
  end

  initial begin
    bit a0, a1;
    int order, n;
    for (int r = 0; r < 2; r++) begin
      req[r] = 0; rnw[r] = 1; adr[r] = '0; wd[r] = '0; be[r] = '0;
    end
    init_seq();

    // Both requesters held: grants alternate starting with requester 0
    req[0] = 1; rnw[0] = 1; adr[0] = 32'h0;
    req[1] = 1; rnw[1] = 1; adr[1] = 32'h4;
    for (int k = 0; k < 6; k++) begin
      step(a0, a1);
      order = a1 ? 1 : 0;
      chk("alt_order", 32'(order), 32'(k % 2));
    end
    req[0] = 0; req[1] = 0;
    idle(3);

    // Write then read back
    do_op(0, 0, 32'h10, 32'hDEADBEEF, 4'hF);
    do_op(0, 1, 32'h10, 32'h0, 4'h0);
    idle(3);

    // Partial byte writes and an all-zero byte-enable write
    do_op(1, 0, 32'h20, 32'hAABBCCDD, 4'hF);
    do_op(1, 0, 32'h20, 32'h11223344, 4'b0011);
    do_op(0, 1, 32'h20, 32'h0, 4'h0);
    do_op(0, 0, 32'h20, 32'hFFFFFFFF, 4'b0000);
    do_op(1, 1, 32'h20, 32'h0, 4'h0);
    // Unaligned read address
    do_op(1, 1, 32'h13, 32'h0, 4'h0);
    idle(3);

    // Randomised traffic from both requesters
    for (int k = 0; k < 400; k++) begin
      for (int r = 0; r < 2; r++) begin
        if (!req[r] && $urandom_range(0, 3) != 0) begin
          req[r] = 1; rnw[r] = $urandom_range(0, 1) == 1;
          adr[r] = $urandom; wd[r] = $urandom; be[r] = 4'($urandom);
        end
      end
      step(a0, a1);
      if (a0) req[0] = 0;
      if (a1) req[1] = 0;
    end
    n = 0;
    while ((req[0] || req[1]) && n < 20) begin
      step(a0, a1);
      if (a0) req[0] = 0;
      if (a1) req[1] = 0;
      n++;
    end
    req[0] = 0; req[1] = 0;
    idle(4);

    // Reset during an in-flight read: no strobe, zero-fill repeats
    do_op(0, 0, 32'h24, 32'h12345678, 4'hF);
    do_op(0, 1, 32'h24, 32'h0, 4'h0);
    init_seq();
    do_op(1, 1, 32'h24, 32'h0, 4'h0);
    idle(4);

    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
